// File: rtl/cpu_defs.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: opcodes, functs,
// control-field codes, FSM states and the decoded control bundle.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;

  localparam logic [1:0] REGDST_RD = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MEM  = 2'b01;
  localparam logic [1:0] MTR_PC   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_ERROR
  } state_t;

  typedef struct packed {
    logic [1:0] regdst;
    logic [2:0] alu_cntrl;
    logic       alu_src;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] mem_to_reg;
    logic       br_eq;
    logic       br_ne;
    logic       jump;
    logic       jr;
    logic       illegal;
  } ctrl_t;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decode: opcode/funct to control fields. Any
// unsupported encoding raises illegal with every other field left at zero.
module cpu_decoder
  import cpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_LW: begin
        ctrl.regdst     = REGDST_RT;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_cntrl  = ALU_ADD;
        ctrl.mem_to_reg = MTR_MEM;
        ctrl.reg_wr     = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_cntrl = ALU_ADD;
        ctrl.mem_wr    = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regdst    = REGDST_RT;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_cntrl = ALU_ADD;
        ctrl.reg_wr    = 1'b1;
      end
      OP_XORI: begin
        ctrl.regdst    = REGDST_RT;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_cntrl = ALU_XOR;
        ctrl.reg_wr    = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_cntrl = ALU_SUB;
        ctrl.br_eq     = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_cntrl = ALU_SUB;
        ctrl.br_ne     = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.regdst     = REGDST_RA;
        ctrl.mem_to_reg = MTR_PC;
        ctrl.reg_wr     = 1'b1;
      end
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            ctrl.alu_cntrl = ALU_ADD;
            ctrl.reg_wr    = 1'b1;
          end
          FN_SUB: begin
            ctrl.alu_cntrl = ALU_SUB;
            ctrl.reg_wr    = 1'b1;
          end
          FN_SLT: begin
            ctrl.alu_cntrl = ALU_SLT;
            ctrl.reg_wr    = 1'b1;
          end
          FN_JR:   ctrl.jr      = 1'b1;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle sequencer for the core datapath: owns PC and IR, fetches over
// req/ack, and steps each instruction through FETCH/DECODE/EXEC/WB.
//
//   state  | meaning
//   IDLE   | waiting for run
//   FETCH  | imem_req high, waiting for imem_ack (bounded by FETCH_TIMEOUT)
//   DECODE | IR valid, controls driven, illegal encodings trapped
//   EXEC   | datapath evaluates; is_zero and Da captured at the end
//   WB     | single-cycle write strobe, retired pulse, PC update
//   ERROR  | halted until reset
module cpu_controller
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] immediate,
  output logic [31:0] new_PC,
  output logic [1:0]  regdst,
  output logic [2:0]  ALUcntrl,
  output logic        ALUsrc,
  output logic        MemWr,
  output logic        RegWr,
  output logic [1:0]  MemtoReg,
  input  logic [31:0] Da,
  input  logic        is_zero,
  output logic        retired,
  output logic        halted
);

  localparam logic [31:0] TO_LIM = 32'(FETCH_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic [31:0] da_q, da_d;
  logic        req_q, req_d;
  logic        wb_q, wb_d;
  logic        retired_q, retired_d;
  logic        halted_q, halted_d;

  ctrl_t       ctrl;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] cnt_inc;

  cpu_decoder u_decoder (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .ctrl   (ctrl)
  );

  assign pc_plus4 = pc_q + 32'd4;
  // Saturating so a disabled timeout never wraps back onto a small limit.
  assign cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    next_pc = pc_plus4;
    if ((ctrl.br_eq && zero_q) || (ctrl.br_ne && !zero_q)) begin
      next_pc = pc_plus4 + branch_offset(ir_q[15:0]);
    end else if (ctrl.jump) begin
      next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    end else if (ctrl.jr) begin
      next_pc = da_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    da_d      = da_q;
    req_d     = 1'b0;
    wb_d      = 1'b0;
    retired_d = 1'b0;
    halted_d  = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_inc;
          if ((TO_LIM != 32'd0) && (cnt_inc == TO_LIM)) begin
            state_d  = ST_ERROR;
            halted_d = 1'b1;
          end else begin
            req_d = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (ctrl.illegal) begin
          state_d  = ST_ERROR;
          halted_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        zero_d    = is_zero;
        da_d      = Da;
        state_d   = ST_WB;
        wb_d      = 1'b1;
        retired_d = 1'b1;
      end
      ST_WB: begin
        pc_d    = next_pc;
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_ERROR: halted_d = 1'b1;
      default: begin
        state_d  = ST_ERROR;
        halted_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      da_q      <= '0;
      req_q     <= 1'b0;
      wb_q      <= 1'b0;
      retired_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      da_q      <= da_d;
      req_q     <= req_d;
      wb_q      <= wb_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign immediate = ir_q[15:0];
  assign new_PC    = pc_plus4;
  assign regdst    = ctrl.regdst;
  assign ALUcntrl  = ctrl.alu_cntrl;
  assign ALUsrc    = ctrl.alu_src;
  assign MemtoReg  = ctrl.mem_to_reg;
  assign RegWr     = ctrl.reg_wr & wb_q;
  assign MemWr     = ctrl.mem_wr & wb_q;
  assign retired   = retired_q;
  assign halted    = halted_q;

endmodule
